cpu_txbuf: RTL

Parametrised character transmit buffer and framer for the B-Processor print path. It accepts 1..LANES packed characters per cycle from the CPU datapath's print operations into a DEPTH-entry FIFO. It emits them one per cycle on a CWIDTH-bit parallel `tx` line, framing each burst as a start symbol (all zeros), the characters, then at least STOP_CYCLES idle symbols (all ones). It replaces the unbounded string buffer with synthesizable storage, backpressure and overflow reporting.

---
 rtl/cpu_txbuf.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/cpu_txbuf.sv
// Character transmit buffer and start/stop framer for the print path.
// Optional macro TXBUF_ZERO_SKIP_EN: drop and compact NUL lanes before enqueue.
module cpu_txbuf #(
  parameter int unsigned CWIDTH      = 7,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned LANES       = 4,
  parameter int unsigned STOP_CYCLES = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [LANES*CWIDTH-1:0]      push_data,
  input  logic [$clog2(LANES+1)-1:0]   push_cnt,
  output logic                         push_ready,
  output logic [CWIDTH-1:0]            tx,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         overflow
);

  localparam int unsigned LVLW = $clog2(DEPTH + 1);
  localparam int unsigned PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned SCW  = (STOP_CYCLES > 1) ? $clog2(STOP_CYCLES) : 1;

`ifdef TXBUF_ZERO_SKIP_EN
  localparam bit ZERO_SKIP = 1'b1;
`else
  localparam bit ZERO_SKIP = 1'b0;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_STOP} state_e;

  state_e            state_q, state_d;
  logic [PTRW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LVLW-1:0]   level_q, level_d;
  logic [SCW-1:0]    scnt_q, scnt_d;
  logic [CWIDTH-1:0] tx_q, tx_d;
  logic              overflow_q, overflow_d;
  logic              push_ready_q, push_ready_d;
  logic              busy_q, busy_d;
  logic [CWIDTH-1:0] mem_q [DEPTH];
  logic [CWIDTH-1:0] mem_d [DEPTH];

  int unsigned       cnt_eff, n_push, wr_idx;
  logic [CWIDTH-1:0] lane_c;
  logic              accept, pop;

  // Push side: count enqueue lanes, all-or-nothing acceptance, compacted write
  always_comb begin
    cnt_eff    = (32'(push_cnt) > LANES) ? LANES : 32'(push_cnt);
    n_push     = 0;
    wr_idx     = 0;
    lane_c     = '0;
    mem_d      = mem_q;
    wptr_d     = wptr_q;
    for (int unsigned i = 0; i < LANES; i++) begin
      lane_c = push_data[(LANES-1-i)*CWIDTH +: CWIDTH];
      if (i < cnt_eff && (!ZERO_SKIP || lane_c != '0)) n_push = n_push + 1;
    end
    accept     = (n_push != 0) && (n_push <= DEPTH - 32'(level_q));
    overflow_d = overflow_q | ((n_push != 0) && !accept);
    if (accept) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        lane_c = push_data[(LANES-1-i)*CWIDTH +: CWIDTH];
        if (i < cnt_eff && (!ZERO_SKIP || lane_c != '0)) begin
          mem_d[PTRW'(32'(wptr_q) + wr_idx)] = lane_c;
          wr_idx = wr_idx + 1;
        end
      end
      wptr_d = PTRW'(32'(wptr_q) + n_push);
    end
  end

  // Framer: one symbol per cycle, decisions use the registered level only
  always_comb begin
    state_d = state_q;
    tx_d    = '1;
    scnt_d  = scnt_q;
    pop     = 1'b0;
    rptr_d  = rptr_q;
    case (state_q)
      ST_DATA: begin
        if (level_q != '0) begin
          tx_d = mem_q[rptr_q];
          pop  = 1'b1;
        end else begin
          scnt_d  = SCW'(STOP_CYCLES - 1);
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (scnt_q != '0) begin
          scnt_d = scnt_q - 1'b1;
        end else if (level_q != '0) begin
          tx_d    = '0;
          state_d = ST_DATA;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        if (level_q != '0) begin
          tx_d    = '0;
          state_d = ST_DATA;
        end
      end
    endcase
    if (pop) rptr_d = rptr_q + 1'b1;
  end

  always_comb begin
    level_d      = LVLW'(32'(level_q) + (accept ? n_push : 32'd0) - 32'(pop));
    push_ready_d = (DEPTH - 32'(level_d)) >= LANES;
    busy_d       = (state_d != ST_IDLE) || (level_d != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      wptr_q       <= '0;
      rptr_q       <= '0;
      level_q      <= '0;
      scnt_q       <= '0;
      tx_q         <= '1;
      overflow_q   <= 1'b0;
      push_ready_q <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      level_q      <= level_d;
      scnt_q       <= scnt_d;
      tx_q         <= tx_d;
      overflow_q   <= overflow_d;
      push_ready_q <= push_ready_d;
      busy_q       <= busy_d;
    end
  end

  // Storage carries no reset; stale entries are never read past level
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign tx         = tx_q;
  assign level      = level_q;
  assign overflow   = overflow_q;
  assign push_ready = push_ready_q;
  assign busy       = busy_q;

endmodule
